// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES key-schedule types, constants and GF(2^8) helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int WORD_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CALC      = 3'd1,
        ST_SBOX_WAIT = 3'd2,
        ST_READY     = 3'd3,
        ST_STREAM    = 3'd4
    } ks_state_t;

    // Round constants 0x01..0x36, first entry in the top byte
    localparam logic [79:0] RCON_TABLE = 80'h01_02_04_08_10_20_40_80_1b_36;
    localparam logic [7:0]  RCON_INIT  = RCON_TABLE[79:72];

    function automatic logic [WORD_DATA_WIDTH-1:0] rot_word(input logic [WORD_DATA_WIDTH-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_word_ram.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_word_ram
// Description : Expanded-key word store, one write port plus seed-key load,
//               three asynchronous read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_word_ram
    import aes_pkg::*;
#(
    parameter int DEPTH      = 44,
    parameter int SEED_WORDS = 4,
    parameter int AW         = 6
) (
    input  logic                                  clock,
    input  logic                                  seed_load,
    input  logic [WORD_DATA_WIDTH*SEED_WORDS-1:0] seed,
    input  logic                                  wr_en,
    input  logic [AW-1:0]                         wr_addr,
    input  logic [WORD_DATA_WIDTH-1:0]            wr_data,
    input  logic [AW-1:0]                         rd_addr_a,
    input  logic [AW-1:0]                         rd_addr_b,
    input  logic [AW-1:0]                         rd_addr_c,
    output logic [WORD_DATA_WIDTH-1:0]            rd_data_a,
    output logic [WORD_DATA_WIDTH-1:0]            rd_data_b,
    output logic [WORD_DATA_WIDTH-1:0]            rd_data_c
);

    logic [WORD_DATA_WIDTH-1:0] r_mem [DEPTH];

    // The seed key lands in words 0..Nk-1 in one cycle; MSB word is w[0]
    always_ff @(posedge clock) begin
        if (seed_load) begin
            for (int k = 0; k < SEED_WORDS; k++) begin
                r_mem[k] <= seed[WORD_DATA_WIDTH*(SEED_WORDS-1-k) +: WORD_DATA_WIDTH];
            end
        end else if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (int'(rd_addr_a) < DEPTH) ? r_mem[rd_addr_a] : '0;
    assign rd_data_b = (int'(rd_addr_b) < DEPTH) ? r_mem[rd_addr_b] : '0;
    assign rd_data_c = (int'(rd_addr_c) < DEPTH) ? r_mem[rd_addr_c] : '0;

endmodule
`default_nettype wire

// File: rtl/aes_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_schedule
// Description : AES-128/192/256 key expansion with external S-box and
//               bidirectional round-key streaming.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int KEY_WORDS = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [WORD_DATA_WIDTH*KEY_WORDS-1:0] key_in,
    input  logic                                 key_in_vld,
    input  logic                                 rnd_key_dir,
    output logic                                 key_exp_sbox_req,
    output logic [WORD_DATA_WIDTH-1:0]           key_exp_sbox_word,
    input  logic                                 key_exp_sbox_data_vld,
    input  logic [WORD_DATA_WIDTH-1:0]           key_exp_sbox_data,
    input  logic                                 rnd_key_gen,
    output logic [WORD_DATA_WIDTH-1:0]           rnd_word_key_val,
    output logic                                 rnd_word_key_val_vld,
    output logic                                 rnd_key_last,
    output logic                                 key_available,
    output logic                                 key_exp_busy
);

    localparam int NR          = KEY_WORDS + 6;
    localparam int TOTAL_WORDS = 4 * (NR + 1);
    localparam int AW          = $clog2(TOTAL_WORDS);
    localparam int PW          = AW - 2;

    localparam logic [AW-1:0] C_NK     = AW'(KEY_WORDS);
    localparam logic [AW-1:0] C_TOTAL  = AW'(TOTAL_WORDS);
    localparam logic [PW-1:0] C_NR     = PW'(NR);
    localparam logic [2:0]    C_J_LAST = 3'(KEY_WORDS - 1);

    ks_state_t                  r_state;
    logic [AW-1:0]              r_i;
    logic [2:0]                 r_j;        // i mod Nk, tracked incrementally
    logic [7:0]                 r_rcon;
    logic                       r_rot;
    logic                       r_dir;
    logic [PW-1:0]              r_ptr;
    logic [2:0]                 r_cnt;

    logic [WORD_DATA_WIDTH-1:0] w_word_a;
    logic [WORD_DATA_WIDTH-1:0] w_word_b;
    logic [WORD_DATA_WIDTH-1:0] w_word_c;
    logic [WORD_DATA_WIDTH-1:0] w_wd;
    logic [AW-1:0]              w_addr_a;
    logic [AW-1:0]              w_addr_b;
    logic [AW-1:0]              w_addr_c;
    logic                       w_sbox_case;
    logic                       w_we;
    logic [2:0]                 w_j_next;
    logic [PW-1:0]              w_ptr_final;
    logic [PW-1:0]              w_ptr_next;

    assign w_addr_a    = r_i - C_NK;
    assign w_addr_b    = r_i - AW'(1);
    assign w_addr_c    = {r_ptr, r_cnt[1:0]};
    assign w_sbox_case = (r_j == 3'd0) || ((KEY_WORDS == 8) && (r_j == 3'd4));
    assign w_j_next    = (r_j == C_J_LAST) ? 3'd0 : r_j + 3'd1;
    assign w_ptr_final = r_dir ? '0 : C_NR;
    assign w_ptr_next  = (r_ptr == w_ptr_final) ? (r_dir ? C_NR : '0)
                       : (r_dir ? r_ptr - PW'(1) : r_ptr + PW'(1));

    // Storage writes are suppressed when reset or a new key wins the cycle
    assign w_we = !reset && !key_in_vld &&
                  (((r_state == ST_CALC) && (r_i != C_TOTAL) && !w_sbox_case) ||
                   ((r_state == ST_SBOX_WAIT) && key_exp_sbox_data_vld));
    assign w_wd = (r_state == ST_SBOX_WAIT)
                ? (w_word_a ^ key_exp_sbox_data ^ (r_rot ? {r_rcon, 24'h0} : 32'h0))
                : (w_word_a ^ w_word_b);

    aes_key_word_ram #(
        .DEPTH      (TOTAL_WORDS),
        .SEED_WORDS (KEY_WORDS),
        .AW         (AW)
    ) u_ram (
        .clock     (clock),
        .seed_load (key_in_vld && !reset),
        .seed      (key_in),
        .wr_en     (w_we),
        .wr_addr   (r_i),
        .wr_data   (w_wd),
        .rd_addr_a (w_addr_a),
        .rd_addr_b (w_addr_b),
        .rd_addr_c (w_addr_c),
        .rd_data_a (w_word_a),
        .rd_data_b (w_word_b),
        .rd_data_c (w_word_c)
    );

    always_ff @(posedge clock) begin
        if (reset || key_in_vld) begin
            r_state              <= reset ? ST_IDLE : ST_CALC;
            r_i                  <= reset ? '0 : C_NK;
            r_dir                <= reset ? 1'b0 : rnd_key_dir;
            key_exp_busy         <= !reset;
            r_j                  <= '0;
            r_rcon               <= RCON_INIT;
            r_rot                <= 1'b0;
            r_ptr                <= '0;
            r_cnt                <= '0;
            key_exp_sbox_req     <= 1'b0;
            key_exp_sbox_word    <= '0;
            rnd_word_key_val     <= '0;
            rnd_word_key_val_vld <= 1'b0;
            rnd_key_last         <= 1'b0;
            key_available        <= 1'b0;
        end else begin
            case (r_state)
                ST_CALC: begin
                    if (r_i == C_TOTAL) begin
                        r_state       <= ST_READY;
                        key_available <= 1'b1;
                        key_exp_busy  <= 1'b0;
                        r_ptr         <= r_dir ? C_NR : '0;
                    end else if (w_sbox_case) begin
                        key_exp_sbox_req  <= 1'b1;
                        key_exp_sbox_word <= (r_j == 3'd0) ? rot_word(w_word_b) : w_word_b;
                        r_rot             <= (r_j == 3'd0);
                        r_state           <= ST_SBOX_WAIT;
                    end else begin
                        r_i <= r_i + AW'(1);
                        r_j <= w_j_next;
                    end
                end
                ST_SBOX_WAIT: begin
                    if (key_exp_sbox_data_vld) begin
                        key_exp_sbox_req  <= 1'b0;
                        key_exp_sbox_word <= '0;
                        r_i               <= r_i + AW'(1);
                        r_j               <= w_j_next;
                        if (r_rot) begin
                            r_rcon <= xtime(r_rcon);
                        end
                        r_state <= ST_CALC;
                    end
                end
                ST_READY: begin
                    if (rnd_key_gen) begin
                        rnd_word_key_val     <= w_word_c;
                        rnd_word_key_val_vld <= 1'b1;
                        r_cnt                <= 3'd1;
                        r_state              <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (r_cnt == 3'd4) begin
                        rnd_word_key_val     <= '0;
                        rnd_word_key_val_vld <= 1'b0;
                        rnd_key_last         <= 1'b0;
                        r_cnt                <= '0;
                        r_ptr                <= w_ptr_next;
                        r_state              <= ST_READY;
                    end else begin
                        rnd_word_key_val <= w_word_c;
                        rnd_key_last     <= (r_cnt == 3'd3) && (r_ptr == w_ptr_final);
                        r_cnt            <= r_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
